// File: rtl/ddr_bw_pkg.sv
// Shared definitions for the DDR bandwidth-test sequencer.
//   - seq_state_t : top-level sequencer states
//   - MODE_*      : CTRL_MODE encodings (3 is reserved and runs as MODE_WR_RD)
//   - seq_cfg_t   : run configuration captured on an accepted start
//   - DIR_*       : direction index into the per-direction handshake array
package ddr_bw_pkg;

   localparam int TMO_CYCLES_DEF = 1024;

   localparam logic [1:0] MODE_WR    = 2'd0;
   localparam logic [1:0] MODE_RD    = 2'd1;
   localparam logic [1:0] MODE_WR_RD = 2'd2;

   localparam int DIR_W   = 0;
   localparam int DIR_R   = 1;
   localparam int NUM_DIR = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_REQ,
      ST_W_RUN,
      ST_R_REQ,
      ST_R_RUN,
      ST_NEXT,
      ST_FIN
   } seq_state_t;

   typedef struct packed {
      logic [1:0]  mode;
      logic [31:0] addr;
      logic [31:0] nburst;
   } seq_cfg_t;

endpackage

// File: rtl/bw_engine_handshake.sv
// Per-direction START/IDLE handshake for one DDR traffic engine.
// Ports:
//   clk, rstn : clock, async active-low reset
//   req       : sequencer is in this direction's REQ state
//   run       : sequencer is in this direction's RUN state
//   clr       : clear the cycle accumulator (accepted sequence start)
//   idle      : engine idle input
//   start     : registered engine start output
//   acc       : engine accepted the start this cycle (start high, idle low)
//   fin       : engine back to idle while running
//   tmo       : request has waited too long; sequencer must abort
//   cycles    : saturating busy-cycle accumulator
module bw_engine_handshake
   import ddr_bw_pkg::*;
#(
   parameter int CNT_WIDTH  = 32,
   parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 req,
   input  logic                 run,
   input  logic                 clr,
   input  logic                 idle,
   output logic                 start,
   output logic                 acc,
   output logic                 fin,
   output logic                 tmo,
   output logic [CNT_WIDTH-1:0] cycles
);

   localparam int TW = $clog2(TMO_CYCLES);
   // The abort edge is placed so that DONE (one cycle after FIN entry)
   // lands exactly TMO_CYCLES cycles after the REQ state was entered.
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 2);

   logic [TW-1:0]        tmo_cnt;
   logic                 start_q;
   logic [CNT_WIDTH-1:0] cyc_q;

   assign acc    = req && start_q && !idle;
   assign tmo    = req && !acc && (tmo_cnt == TMO_LAST);
   assign fin    = run && idle;
   assign start  = start_q;
   assign cycles = cyc_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         start_q <= 1'b0;
         tmo_cnt <= '0;
         cyc_q   <= '0;
      end else begin
         // Raise START only once the engine reports idle; hold it until the
         // engine drops idle, or until the request is abandoned.
         if (!req || acc || tmo)
            start_q <= 1'b0;
         else if (idle)
            start_q <= 1'b1;

         tmo_cnt <= req ? tmo_cnt + 1'b1 : '0;

         if (clr)
            cyc_q <= '0;
         else if (((req && start_q) || run) && (cyc_q != '1))
            cyc_q <= cyc_q + 1'b1;
      end
   end

endmodule

// File: rtl/ddr_bw_seq.sv
// DDR bandwidth-test sequencer: runs NITER iterations of write, read or
// write-then-read engine runs over one buffer and accumulates busy cycles.
// Ports:
//   clk, rstn                 : AXI clock, async active-low reset
//   CTRL_START/MODE/ADDR/
//   CTRL_NBURST/NITER         : run request from the register file
//   W*/R* START/ADDR/NBURST   : engine controls (ADDR/NBURST hold latched cfg)
//   WIDLE_REG, RIDLE_REG      : engine idle inputs
//   BUSY, DONE, ERR           : status (DONE one-cycle pulse, ERR sticky)
//   ITER_CNT, WCYCLES, RCYCLES: completed iterations, busy-cycle counts
module ddr_bw_seq
   import ddr_bw_pkg::*;
#(
   parameter int CNT_WIDTH  = 32,
   parameter int ITER_WIDTH = 16,
   parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  CTRL_START,
   input  logic [1:0]            CTRL_MODE,
   input  logic [31:0]           CTRL_ADDR,
   input  logic [31:0]           CTRL_NBURST,
   input  logic [ITER_WIDTH-1:0] CTRL_NITER,
   output logic                  WSTART_REG,
   output logic [31:0]           WADDR_REG,
   output logic [31:0]           WNBURST_REG,
   input  logic                  WIDLE_REG,
   output logic                  RSTART_REG,
   output logic [31:0]           RADDR_REG,
   output logic [31:0]           RNBURST_REG,
   input  logic                  RIDLE_REG,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERR,
   output logic [ITER_WIDTH-1:0] ITER_CNT,
   output logic [CNT_WIDTH-1:0]  WCYCLES,
   output logic [CNT_WIDTH-1:0]  RCYCLES
);

   seq_state_t            state;
   seq_cfg_t              cfg;
   logic [ITER_WIDTH-1:0] niter_q, iter_q, iter_nxt;
   logic                  busy_q, done_q, err_q;
   logic                  accept, wr_en, rd_en;

   logic [NUM_DIR-1:0]                req, run, acc, fin, tmo, idle, start;
   logic [NUM_DIR-1:0][CNT_WIDTH-1:0] cycles;

   assign accept   = CTRL_START && !busy_q && (state == ST_IDLE);
   assign wr_en    = (cfg.mode != MODE_RD);
   assign rd_en    = (cfg.mode != MODE_WR);
   assign iter_nxt = iter_q + ITER_WIDTH'(1);

   assign req[DIR_W] = (state == ST_W_REQ);
   assign run[DIR_W] = (state == ST_W_RUN);
   assign req[DIR_R] = (state == ST_R_REQ);
   assign run[DIR_R] = (state == ST_R_RUN);
   assign idle       = {RIDLE_REG, WIDLE_REG};

   for (genvar d = 0; d < NUM_DIR; d++) begin : g_hs
      bw_engine_handshake #(
         .CNT_WIDTH  (CNT_WIDTH),
         .TMO_CYCLES (TMO_CYCLES)
      ) u_hs (
         .clk    (clk),
         .rstn   (rstn),
         .req    (req[d]),
         .run    (run[d]),
         .clr    (accept),
         .idle   (idle[d]),
         .start  (start[d]),
         .acc    (acc[d]),
         .fin    (fin[d]),
         .tmo    (tmo[d]),
         .cycles (cycles[d])
      );
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         cfg     <= '0;
         niter_q <= '0;
         iter_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               // BUSY stays up through the DONE cycle, so a start arriving
               // alongside DONE is still ignored.
               if (accept) begin
                  cfg.mode   <= (CTRL_MODE == 2'd3) ? MODE_WR_RD : CTRL_MODE;
                  cfg.addr   <= CTRL_ADDR;
                  cfg.nburst <= CTRL_NBURST;
                  niter_q    <= CTRL_NITER;
                  iter_q     <= '0;
                  err_q      <= 1'b0;
                  busy_q     <= 1'b1;
                  if ((CTRL_NBURST == '0) || (CTRL_NITER == '0))
                     state <= ST_FIN;
                  else
                     state <= (CTRL_MODE == MODE_RD) ? ST_R_REQ : ST_W_REQ;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            ST_W_REQ: begin
               if (acc[DIR_W]) begin
                  state <= ST_W_RUN;
               end else if (tmo[DIR_W]) begin
                  err_q <= 1'b1;
                  state <= ST_FIN;
               end
            end
            ST_W_RUN: if (fin[DIR_W]) state <= rd_en ? ST_R_REQ : ST_NEXT;
            ST_R_REQ: begin
               if (acc[DIR_R]) begin
                  state <= ST_R_RUN;
               end else if (tmo[DIR_R]) begin
                  err_q <= 1'b1;
                  state <= ST_FIN;
               end
            end
            ST_R_RUN: if (fin[DIR_R]) state <= ST_NEXT;
            ST_NEXT: begin
               iter_q <= iter_nxt;
               if (iter_nxt == niter_q)
                  state <= ST_FIN;
               else
                  state <= wr_en ? ST_W_REQ : ST_R_REQ;
            end
            ST_FIN: begin
               done_q <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign WSTART_REG  = start[DIR_W];
   assign RSTART_REG  = start[DIR_R];
   assign WADDR_REG   = cfg.addr;
   assign RADDR_REG   = cfg.addr;
   assign WNBURST_REG = cfg.nburst;
   assign RNBURST_REG = cfg.nburst;
   assign BUSY        = busy_q;
   assign DONE        = done_q;
   assign ERR         = err_q;
   assign ITER_CNT    = iter_q;
   assign WCYCLES     = cycles[DIR_W];
   assign RCYCLES     = cycles[DIR_R];

endmodule

// File: tb/tb_ddr_bw_seq.sv
// Self-checking bench for ddr_bw_seq: behavioural engine models plus a
// run-level expectation model (pulse counts, W/R order, cycle totals).
module tb_ddr_bw_seq;

   localparam int CW    = 8;     // small accumulators so saturation is reachable
   localparam int IW    = 16;
   localparam int TMO   = 1024;
   localparam int LIMIT = 4000;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          CTRL_START = 1'b0;
   logic [1:0]    CTRL_MODE = '0;
   logic [31:0]   CTRL_ADDR = '0;
   logic [31:0]   CTRL_NBURST = '0;
   logic [IW-1:0] CTRL_NITER = '0;
   logic          WSTART_REG, RSTART_REG, BUSY, DONE, ERR;
   logic [31:0]   WADDR_REG, WNBURST_REG, RADDR_REG, RNBURST_REG;
   logic          WIDLE_REG = 1'b1;
   logic          RIDLE_REG = 1'b1;
   logic [IW-1:0] ITER_CNT;
   logic [CW-1:0] WCYCLES, RCYCLES;

   always #5 clk = ~clk;

   ddr_bw_seq #(.CNT_WIDTH(CW), .ITER_WIDTH(IW), .TMO_CYCLES(TMO)) dut (
      .clk(clk), .rstn(rstn),
      .CTRL_START(CTRL_START), .CTRL_MODE(CTRL_MODE), .CTRL_ADDR(CTRL_ADDR),
      .CTRL_NBURST(CTRL_NBURST), .CTRL_NITER(CTRL_NITER),
      .WSTART_REG(WSTART_REG), .WADDR_REG(WADDR_REG), .WNBURST_REG(WNBURST_REG),
      .WIDLE_REG(WIDLE_REG),
      .RSTART_REG(RSTART_REG), .RADDR_REG(RADDR_REG), .RNBURST_REG(RNBURST_REG),
      .RIDLE_REG(RIDLE_REG),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ITER_CNT(ITER_CNT),
      .WCYCLES(WCYCLES), .RCYCLES(RCYCLES)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint sat(input longint v);
      longint m;
      m = (longint'(1) << CW) - 1;
      return (v > m) ? m : v;
   endfunction

   // Engine model: once START is seen while idle, drops idle after eng_a
   // extra cycles, then stays busy for eng_b cycles. A hung engine never
   // responds.
   int eng_a = 2, eng_b = 20;
   bit w_hang = 1'b0;
   int wwc = 0, wbc = 0, rwc = 0, rbc = 0;

   always @(negedge clk) begin
      if (WIDLE_REG) begin
         if (WSTART_REG && !w_hang) begin
            wwc++;
            if (wwc > eng_a) begin WIDLE_REG = 1'b0; wbc = eng_b; wwc = 0; end
         end else wwc = 0;
      end else begin
         wbc--;
         if (wbc == 0) WIDLE_REG = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (RIDLE_REG) begin
         if (RSTART_REG) begin
            rwc++;
            if (rwc > eng_a) begin RIDLE_REG = 1'b0; rbc = eng_b; rwc = 0; end
         end else rwc = 0;
      end else begin
         rbc--;
         if (rbc == 0) RIDLE_REG = 1'b1;
      end
   end

   // Pulse monitor: start rising edges (with W=0/R=1 order) and DONE cycles.
   int ws_cnt = 0, rs_cnt = 0, done_cnt = 0;
   int order[$];
   logic ws_prev = 1'b0, rs_prev = 1'b0;

   always @(posedge clk) begin
      #1;
      if (WSTART_REG && !ws_prev) begin ws_cnt++; order.push_back(0); end
      if (RSTART_REG && !rs_prev) begin rs_cnt++; order.push_back(1); end
      ws_prev = WSTART_REG;
      rs_prev = RSTART_REG;
      if (DONE) done_cnt++;
   end

   task automatic clear_mon();
      ws_cnt = 0; rs_cnt = 0; done_cnt = 0;
      order.delete();
   endtask

   task automatic run_seq(input logic [1:0] mode, input logic [31:0] addr,
                          input logic [31:0] nburst, input int niter,
                          input int a, input int b, input bit hang,
                          input bit dup, input string tag);
      int  cyc;
      bit  zero, we, re, ok;
      int  exp_q[$];
      longint per;
      eng_a = a; eng_b = b; w_hang = hang;
      clear_mon();
      @(negedge clk);
      CTRL_MODE = mode; CTRL_ADDR = addr; CTRL_NBURST = nburst;
      CTRL_NITER = IW'(niter); CTRL_START = 1'b1;
      @(negedge clk);
      CTRL_START = 1'b0;
      cyc = 0;
      while (done_cnt == 0 && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
         if (dup && cyc == 5) begin
            CTRL_ADDR = ~addr; CTRL_NBURST = nburst + 1; CTRL_MODE = 2'd0;
            CTRL_START = 1'b1;
         end else CTRL_START = 1'b0;
      end
      check({tag, "_done_seen"}, done_cnt > 0, 1);
      check({tag, "_busy_in_done"}, {BUSY, DONE}, 2'b11);
      @(negedge clk);
      check({tag, "_busy_after"}, {BUSY, DONE}, 2'b00);
      repeat (2) @(negedge clk);

      zero = (nburst == 0) || (niter == 0);
      we   = !zero && (mode != 2'd1);
      re   = !zero && (mode != 2'd0) && !hang;
      per  = a + 1 + b;
      if (zero) check({tag, "_done_lat"}, cyc, 1);
      if (hang) begin
         check({tag, "_tmo_lat"}, cyc, TMO);
         check({tag, "_err"}, ERR, 1);
         check({tag, "_ws"}, ws_cnt, 1);
         check({tag, "_iter"}, ITER_CNT, 0);
         check({tag, "_wcyc"}, WCYCLES, sat(TMO - 2));
      end else begin
         check({tag, "_err"}, ERR, 0);
         check({tag, "_ws"}, ws_cnt, we ? niter : 0);
         check({tag, "_iter"}, ITER_CNT, zero ? 0 : niter);
         check({tag, "_wcyc"}, WCYCLES, we ? sat(niter * per) : 0);
      end
      check({tag, "_rs"}, rs_cnt, re ? niter : 0);
      check({tag, "_rcyc"}, RCYCLES, re ? sat(niter * per) : 0);
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_starts_low"}, {WSTART_REG, RSTART_REG}, 2'b00);
      check({tag, "_addr"}, {WADDR_REG, RADDR_REG}, {addr, addr});
      check({tag, "_nburst"}, {WNBURST_REG, RNBURST_REG}, {nburst, nburst});
      if (!hang)
         for (int i = 0; i < (zero ? 0 : niter); i++) begin
            if (we) exp_q.push_back(0);
            if (re) exp_q.push_back(1);
         end
      else exp_q.push_back(0);
      ok = (order.size() == exp_q.size());
      if (ok) foreach (exp_q[i]) if (order[i] != exp_q[i]) ok = 1'b0;
      check({tag, "_order"}, ok, 1);
      w_hang = 1'b0;
   endtask

   initial begin
      int t;
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_status", {BUSY, DONE, ERR, WSTART_REG, RSTART_REG}, 5'b0);
      check("rst_cfg", {WADDR_REG, WNBURST_REG, RADDR_REG, RNBURST_REG}, '0);
      check("rst_cnt", {ITER_CNT, WCYCLES, RCYCLES}, '0);
      rstn = 1'b1;

      run_seq(2'd2, 32'h8000_0000, 32'd4, 3, 2, 20, 1'b0, 1'b0, "m2");
      run_seq(2'd0, 32'h1000_0000, 32'd4, 1, 2, 20, 1'b0, 1'b0, "m0");
      run_seq(2'd2, 32'h0000_4000, 32'd0, 3, 2, 20, 1'b0, 1'b0, "nb0");
      run_seq(2'd1, 32'h0000_8000, 32'd5, 0, 2, 20, 1'b0, 1'b0, "ni0");
      run_seq(2'd0, 32'h0BAD_0000, 32'd4, 2, 2, 20, 1'b1, 1'b0, "tmo");
      run_seq(2'd1, 32'h0000_1200, 32'd3, 2, 1, 6,  1'b0, 1'b0, "post_tmo");
      run_seq(2'd2, 32'h2000_0040, 32'd16, 2, 1, 10, 1'b0, 1'b1, "dup");
      run_seq(2'd3, 32'h3000_0000, 32'd8, 4, 3, 70, 1'b0, 1'b0, "sat");

      for (int i = 0; i < 6; i++)
         run_seq(2'($urandom_range(0, 3)), $urandom, 32'($urandom_range(1, 255)),
                 $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(1, 30),
                 1'b0, 1'b0, $sformatf("rnd%0d", i));

      // Async reset during the second read run
      eng_a = 1; eng_b = 30; w_hang = 1'b0;
      clear_mon();
      @(negedge clk);
      CTRL_MODE = 2'd2; CTRL_ADDR = 32'h4444_0000; CTRL_NBURST = 32'd8;
      CTRL_NITER = IW'(2); CTRL_START = 1'b1;
      @(negedge clk);
      CTRL_START = 1'b0;
      t = 0;
      while (rs_cnt < 2 && t < LIMIT) begin @(negedge clk); t++; end
      check("rrun_reached", rs_cnt, 2);
      repeat (6) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("arst_status", {BUSY, DONE, ERR, WSTART_REG, RSTART_REG}, 5'b0);
      check("arst_cfg", {WADDR_REG, WNBURST_REG, RADDR_REG, RNBURST_REG}, '0);
      check("arst_cnt", {ITER_CNT, WCYCLES, RCYCLES}, '0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      t = 0;
      while (!(RIDLE_REG && WIDLE_REG) && t < LIMIT) begin @(negedge clk); t++; end
      check("eng_idle_after_rst", {RIDLE_REG, WIDLE_REG}, 2'b11);
      run_seq(2'd2, 32'h5555_0000, 32'd2, 2, 2, 9, 1'b0, 1'b0, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
